playback_seq: RTL and testbench

Sequencer for the audio sample path. It replaces the fabric-derived divided clock with a single-clock sample-rate strobe, walks the sample BRAM addresses, and absorbs the BRAM read latency. Each fetched sample goes to the encode/decode/filter chain over a valid/ready handshake. It sits between the debounced start/stop buttons, the `blk_mem_gen_0` sample ROM, and the `encode` input.

---
 rtl/playback_pkg.sv | 16 +
 rtl/pb_tick_gen.sv | 39 +++
 rtl/playback_seq.sv | 182 ++++++++++++++++++
 tb/tb_playback_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/playback_pkg.sv
// playback_pkg: shared state encoding and default timing constants for the
// audio sample playback sequencer.
package playback_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        READ,
        PRESENT
    } pb_state_t;

    localparam int unsigned PB_DIV       = 12500;
    localparam int unsigned PB_LAST_ADDR = 80;
    localparam int unsigned PB_BRAM_LAT  = 1;

endpackage

// File: rtl/pb_tick_gen.sv
// pb_tick_gen: sample-rate strobe. Counts 0..DIV-1 while enabled and emits a
// one-cycle tick on the final count; a synchronous clear holds it at zero.
module pb_tick_gen
    import playback_pkg::*;
#(
    parameter int unsigned DIV = PB_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(DIV - 1));
    assign tick = wrap && !clr;

    // Next count: cleared, wrapped, or incremented.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/playback_seq.sv
// playback_seq: walks the sample BRAM once per sample tick, absorbs the BRAM
// read latency and presents each sample over a valid/ready handshake.
// Optional feature macro: PLAYBACK_SEQ_UNDERRUN_EN (missed-tick counter).
module playback_seq
    import playback_pkg::*;
#(
    parameter int unsigned DIV       = PB_DIV,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LAST_ADDR = PB_LAST_ADDR,
    parameter int unsigned BRAM_LAT  = PB_BRAM_LAT
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        underrun_cnt
);

    pb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_q, lat_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;
    logic              tick;
    logic              tick_clr;
    logic              is_last;
    logic              handshake;
`ifdef PLAYBACK_SEQ_UNDERRUN_EN
    logic [7:0]        under_q, under_d;
`endif

    // Counter idles at zero, and restarts on stop so no stale tick survives.
    assign tick_clr = (state_q == IDLE) || stop;

    pb_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (CLK100MHZ),
        .rst_n (reset_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign is_last      = (addr_q == ADDR_W'(LAST_ADDR));
    assign handshake    = valid_q && sample_ready;
    assign bram_en      = (state_q == READ) && (lat_q == 2'd0);
    assign bram_addr    = addr_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
`ifdef PLAYBACK_SEQ_UNDERRUN_EN
    assign underrun_cnt = under_q;
`else
    assign underrun_cnt = '0;
`endif

    // Next-state, address, latency, pending-tick and output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        valid_d = valid_q;
        data_d  = data_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
`ifdef PLAYBACK_SEQ_UNDERRUN_EN
        under_d = under_q;
`endif

        // A tick arriving while a read/present is in flight is queued; a second
        // one before the queue drains is lost.
        if (tick && (state_q == READ || state_q == PRESENT)) begin
            pend_d = 1'b1;
`ifdef PLAYBACK_SEQ_UNDERRUN_EN
            if (pend_q && under_q != 8'hFF) begin
                under_d = under_q + 8'd1;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_TICK;
                    addr_d  = '0;
                    pend_d  = 1'b0;
`ifdef PLAYBACK_SEQ_UNDERRUN_EN
                    under_d = '0;
`endif
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_d = READ;
                    lat_d   = 2'd0;
                end
            end
            READ: begin
                if (lat_q == 2'(BRAM_LAT)) begin
                    data_d  = bram_dout;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    addr_d  = is_last ? '0 : addr_q + ADDR_W'(1);
                    if (is_last && !loop_en) begin
                        done_d  = 1'b1;
                        pend_d  = 1'b0;
                        state_d = IDLE;
                    end else if (pend_q || tick) begin
                        pend_d  = 1'b0;
                        lat_d   = 2'd0;
                        state_d = READ;
                    end else begin
                        state_d = WAIT_TICK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop overrides everything, including a same-cycle start or handshake.
        if (stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
            addr_d  = '0;
            pend_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

`ifdef PLAYBACK_SEQ_UNDERRUN_EN
    // Missed-tick counter register.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            under_q <= '0;
        end else begin
            under_q <= under_d;
        end
    end
`endif

endmodule

// File: tb/tb_playback_seq.sv
// tb_playback_seq: directed bench for playback_seq at DIV=8, LAST_ADDR=3,
// BRAM_LAT=1, with a 1-cycle-latency BRAM model.
module tb_playback_seq;

    localparam int unsigned DIV  = 8;
    localparam int unsigned LAST = 3;
    localparam int unsigned LAT  = 1;
`ifdef PLAYBACK_SEQ_UNDERRUN_EN
    localparam logic [7:0] UNDER_EXP = 8'd1;
`else
    localparam logic [7:0] UNDER_EXP = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       ready = 1'b0;
    logic       bram_en;
    logic [7:0] bram_addr;
    logic [7:0] bram_dout = 8'h00;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       busy;
    logic       done;
    logic [7:0] underrun_cnt;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int         hs_cyc[$];
    logic [7:0] hs_addr[$];
    logic [7:0] hs_data[$];
    int         done_cyc[$];

    playback_seq #(
        .DIV       (DIV),
        .ADDR_W    (8),
        .DATA_W    (8),
        .LAST_ADDR (LAST),
        .BRAM_LAT  (LAT)
    ) dut (
        .CLK100MHZ    (clk),
        .reset_n      (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout),
        .sample_valid (sample_valid),
        .sample_ready (ready),
        .sample_data  (sample_data),
        .busy         (busy),
        .done         (done),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem(input logic [7:0] a);
        return a * 8'd3 + 8'h11;
    endfunction

    always @(posedge clk) if (bram_en) bram_dout <= mem(bram_addr);

    always @(negedge clk) begin
        if (sample_valid && ready) begin
            hs_cyc.push_back(cyc);
            hs_addr.push_back(bram_addr);
            hs_data.push_back(sample_data);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic clear_log();
        hs_cyc.delete();
        hs_addr.delete();
        hs_data.delete();
        done_cyc.delete();
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Checks n handshakes at s+11+8i with addresses in addr_seq order.
    task automatic check_pass(input string tag, input int s, input int n,
                              input logic [7:0] addr_seq[8], input int done_at);
        check({tag, "_hs_count"}, hs_cyc.size(), n);
        for (int i = 0; i < n && i < hs_cyc.size(); i++) begin
            check({tag, "_hs_cyc"}, hs_cyc[i] - s, 11 + 8 * i);
            check({tag, "_hs_addr"}, hs_addr[i], addr_seq[i]);
            check({tag, "_hs_data"}, hs_data[i], mem(addr_seq[i]));
        end
        check({tag, "_done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0] - s, done_at);
    endtask

    initial begin
        int s;
        int s2;
        int busy_seen;
        int valid_seen;
        logic [7:0] seq_lin[8];
        logic [7:0] seq_loop[8];
        seq_lin  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
        seq_loop = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};

        // Reset values
        #1;
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_underrun", underrun_cnt, 0);
        step(3);
        rst_n = 1'b1;

        // Non-looped pass, start at cycle 10
        step_to(10);
        ready = 1'b1;
        clear_log();
        pulse_start(s);
        check("start_busy", busy, 1);
        step_to(s + 46);
        check_pass("lin", s, 4, seq_lin, 36);
        if (hs_cyc.size() > 0) check("lin_first_abs", hs_cyc[0], 21);
        check("lin_busy_end", busy, 0);
        check("lin_underrun", underrun_cnt, 0);

        // Looped pass; loop_en dropped mid-way
        clear_log();
        loop_en = 1'b1;
        pulse_start(s);
        step_to(s + 50);
        loop_en = 1'b0;
        step_to(s + 75);
        check_pass("loop", s, 8, seq_loop, 68);

        // Backpressure: ready low for cycles s+11..s+30
        clear_log();
        ready = 1'b0;
        pulse_start(s);
        step_to(s + 20);
        check("bp_valid_mid", sample_valid, 1);
        check("bp_data_mid", sample_data, mem(8'd0));
        step_to(s + 30);
        check("bp_data_late", sample_data, mem(8'd0));
        check("bp_underrun_mid", underrun_cnt, UNDER_EXP);
        step(1);
        ready = 1'b1;
        step_to(s + 50);
        check("bp_hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            check("bp_hs0", hs_cyc[0] - s, 31);
            check("bp_hs1", hs_cyc[1] - s, 34);
            check("bp_hs2", hs_cyc[2] - s, 37);
            check("bp_hs3", hs_cyc[3] - s, 43);
            check("bp_addr3", hs_addr[3], 3);
            check("bp_data2", hs_data[2], mem(8'd2));
        end
        check("bp_done_count", done_cyc.size(), 1);
        check("bp_underrun_end", underrun_cnt, UNDER_EXP);

        // Stop together with start at address 2
        clear_log();
        pulse_start(s);
        step_to(s + 24);
        check("stop_pre_addr", bram_addr, 2);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_valid", sample_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_addr", bram_addr, 0);
        check("stop_done", done, 0);
        step(20);
        check("stop_idle_busy", busy, 0);
        check("stop_no_done", done_cyc.size(), 0);
        check("stop_hs_count", hs_cyc.size(), 2);
        clear_log();
        pulse_start(s2);
        step_to(s2 + 43);
        check_pass("replay", s2, 4, seq_lin, 36);

        // Async reset while in PRESENT
        clear_log();
        ready = 1'b0;
        pulse_start(s);
        step_to(s + 15);
        check("ar_pre_valid", sample_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", sample_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_data", sample_data, 0);
        check("ar_addr", bram_addr, 0);
        check("ar_bram_en", bram_en, 0);
        check("ar_done", done, 0);
        check("ar_underrun", underrun_cnt, 0);
        step(1);
        rst_n = 1'b1;
        clear_log();
        busy_seen  = 0;
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (busy) busy_seen++;
            if (sample_valid) valid_seen++;
        end
        check("ar_busy_after", busy_seen, 0);
        check("ar_valid_after", valid_seen, 0);
        check("ar_done_after", done_cyc.size(), 0);

        // Start pulses while busy are ignored
        clear_log();
        ready = 1'b1;
        pulse_start(s);
        step_to(s + 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step_to(s + 22);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step_to(s + 46);
        check_pass("busy_start", s, 4, seq_lin, 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
